mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit. It is a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles and drives the shared-datapath muxes and enables. It adds a memory ready/request handshake with a bounded wait timeout, illegal-opcode trapping, and a width-parametrised ALU control field. It sits between the instruction register and the multicycle datapath, and replaces the single-cycle decoder pair.

Parameters:
- ALUCTL_W, 3: width of alu_control. Must be >= 3; bits above [2:0] are driven 0.
- WAIT_MAX, 15: maximum cycles spent waiting for mem_ready in one memory state before a bus error is flagged. Range 1..255.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- opcode, input, 6: instr[31:26] from the instruction register.
- funct, input, 6: instr[5:0].
- zero, input, 1: ALU zero flag.
- mem_ready, input, 1: memory completes the current access this cycle.
- mem_req, output, 1: memory access request.
- mem_write, output, 1: store strobe, valid with mem_req.
- iord, output, 1: 0 = PC address, 1 = ALUOut address.
- ir_write, output, 1: load the instruction register.
- pc_en, output, 1: PC load enable = pc_write | (branch & taken).
- pc_src, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a, output, 1: 0 = PC, 1 = A.
- alu_src_b, output, 2: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2.
- alu_control, output, ALUCTL_W: ALU operation code.
- reg_write, output, 1: register file write enable.
- reg_dst, output, 1: 1 = rd, 0 = rt.
- mem_reg, output, 1: 1 = write back Data register, 0 = ALUOut.
- illegal, output, 1: one-cycle pulse on an unsupported opcode or funct.
- bus_err, output, 1: one-cycle pulse on a memory wait timeout.
- state, output, 4: current state encoding, for debug.

Behaviour:
- States, with encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12..15 are unused and go to FETCH.
- Reset (async, reset_n = 0): state = FETCH, wait counter = 0, illegal = 0, bus_err = 0. All outputs are combinational from state and inputs.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_control = add (010), pc_src = 00.
  - While mem_ready = 0: hold state; ir_write = 0, pc_en = 0.
  - With mem_ready = 1: ir_write = 1, pc_en = 1, next state DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu add (branch target). Dispatch on opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other opcode: illegal pulses, next state FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD and MEMWR: mem_req = 1, iord = 1; MEMWR also drives mem_write = 1. Hold until mem_ready = 1. On completion MEMRD -> MEMWB, MEMWR -> FETCH.
- MEMWB: reg_write = 1, reg_dst = 0, mem_reg = 1. Next state FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00. funct decode:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - Unknown funct: illegal pulses and next state is FETCH, so ALUWB is skipped. Otherwise next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_reg = 0. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub (110), pc_src = 01, taken = zero. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, add. Next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_reg = 0. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.
- Wait counter:
  - Clears on entry to every memory state.
  - Increments each cycle mem_ready = 0 in FETCH, MEMRD or MEMWR.
  - When the count reaches WAIT_MAX and mem_ready is still 0: bus_err pulses, next state FETCH, no ir_write, no pc_en, no mem_write side effect is claimed.
  - mem_ready = 1 on the WAIT_MAX cycle wins: normal completion, no bus_err.
- Outputs not listed for a state default to 0, with alu_control = 010.

Optional Feature:
- CTRL_BNE_EN defined:
  - Opcode 000101 (bne) dispatches from DECODE to BRANCH.
  - In BRANCH, taken = ~zero for bne and zero for beq. The opcode is captured at DECODE so this holds even if the instruction register changes.
- CTRL_BNE_EN undefined: opcode 000101 is illegal.

Test Plan:
- reset_n low mid-EXEC -> state = 0 immediately (asynchronous); after release, FETCH with mem_ready = 1 gives ir_write = 1 and pc_en = 1 in the same cycle.
- lw (opcode 100011), mem_ready always 1 -> state sequence 0, 1, 2, 3, 4, 0; reg_write = 1 and mem_reg = 1 only in state 4.
- R-type sub (funct 100010) -> alu_control = 110 in EXEC; reg_write = 1 and reg_dst = 1 in ALUWB; 4 cycles in total.
- beq with zero = 1 -> pc_en = 1 and pc_src = 01 in BRANCH; with zero = 0 -> pc_en = 0.
- sw with mem_ready held 0 and WAIT_MAX = 3 -> MEMWR held with mem_write = 1 for 3 cycles, then bus_err pulses once and state returns to 0.
- opcode 111111 -> illegal = 1 for one cycle in DECODE, then FETCH; opcode 000101 is illegal only when CTRL_BNE_EN is undefined.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake and traps
//
// Sequences FETCH/DECODE/execute/memory/writeback for lw, sw, R-type, beq,
// addi and j over the shared multicycle datapath. All control outputs are
// combinational from the current state and inputs. The state register,
// memory wait counter and captured opcode are the only storage.
//
// Optional feature macro: CTRL_BNE_EN (adds bne, taken on ~zero).
//
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   opcode, funct        instr[31:26], instr[5:0] from the instruction register
//   zero                 ALU zero flag
//   mem_ready            memory completes the current access this cycle
//   mem_req, mem_write   memory request / store strobe
//   iord                 address select: 0 = PC, 1 = ALUOut
//   ir_write, pc_en      IR load, PC load (pc_write | branch & taken)
//   pc_src               00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a/b, alu_control  ALU operand selects and operation
//   reg_write, reg_dst, mem_reg  register file write controls
//   illegal, bus_err     one-cycle trap pulses
//   state                current state encoding
module mips_multicycle_ctrl #(
  parameter int ALUCTL_W = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_reg,
  output logic                illegal,
  output logic                bus_err,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic [5:0] op_q;       // opcode captured in DECODE, used by later states
  logic       is_mem;
  logic       timeout;
  logic       pc_write;
  logic       branch;
  logic       taken;
  logic [2:0] alu_op;

  assign state   = cur;
  assign is_mem  = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // mem_ready on the limit cycle still completes normally
  assign timeout = is_mem && !mem_ready && (wait_cnt == WAIT_LIM);
  assign pc_en   = pc_write | (branch & taken);

  always_comb begin
    alu_control      = '0;
    alu_control[2:0] = alu_op;
  end

  always_comb begin
    nxt       = cur;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    taken     = 1'b0;
    pc_src    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 3'b010;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    mem_reg   = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:       nxt = S_BRANCH;
`endif
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        // a timed-out store does not assert the strobe on its final cycle
        mem_write = (cur == S_MEMWR) && !timeout;
        if (mem_ready) begin
          nxt = (cur == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (timeout) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        mem_reg   = 1'b1;
        nxt       = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        nxt       = S_ALUWB;
        case (funct)
          6'b100000: alu_op = 3'b010;
          6'b100010: alu_op = 3'b110;
          6'b100100: alu_op = 3'b000;
          6'b100101: alu_op = 3'b001;
          6'b101010: alu_op = 3'b111;
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b110;
        pc_src    = 2'b01;
        branch    = 1'b1;
`ifdef CTRL_BNE_EN
        taken     = (op_q == OP_BNE) ? ~zero : zero;
`else
        taken     = zero;
`endif
        nxt       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        nxt       = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        nxt      = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= S_FETCH;
      wait_cnt <= 8'd0;
      op_q     <= 6'd0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE)
        op_q <= opcode;
      // any state change (or timeout back into FETCH) starts a fresh wait
      if (timeout || (nxt != cur))
        wait_cnt <= 8'd0;
      else if (is_mem && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_control;
  logic       reg_write, reg_dst, mem_reg, illegal, bus_err;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mips_multicycle_ctrl #(.ALUCTL_W(3), .WAIT_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_reg(mem_reg), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  // Leaves the FSM in FETCH, a few ns after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100010;
    #12;
    tests++;
    if (state !== 4'd0 || illegal !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b1) begin
      fails++; $display("FAIL reset_state: state=%0d illegal=%b bus_err=%b mem_req=%b, want 0 0 0 1", state, illegal, bus_err, mem_req);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (state !== 4'd6) begin
      fails++; $display("FAIL reset_reach_exec: state=%0d want 6", state);
    end
    #1 reset_n = 1'b0; #1;
    tests++;
    if (state !== 4'd0) begin
      fails++; $display("FAIL reset_async: state=%0d want 0", state);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    tests++;
    if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
      fails++; $display("FAIL reset_fetch: state=%0d ir_write=%b pc_en=%b, want 0 1 1", state, ir_write, pc_en);
    end
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    do_reset(); opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (state !== 4'(exp_st[i]) || reg_write !== (exp_st[i] == 4) || mem_reg !== (exp_st[i] == 4)) begin
        fails++; $display("FAIL lw_step%0d: state=%0d reg_write=%b mem_reg=%b, want state %0d", i, state, reg_write, mem_reg, exp_st[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    do_reset(); opcode = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (state !== 4'(exp_st[i])) begin
        fails++; $display("FAIL rtype_state%0d: state=%0d want %0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        tests++;
        if (alu_control !== 3'b110 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || illegal !== 1'b0) begin
          fails++; $display("FAIL rtype_exec: alu_control=%b src_a=%b src_b=%b illegal=%b, want 110 1 00 0", alu_control, alu_src_a, alu_src_b, illegal);
        end
      end
      if (i == 3) begin
        tests++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_reg !== 1'b0) begin
          fails++; $display("FAIL rtype_aluwb: reg_write=%b reg_dst=%b mem_reg=%b, want 1 1 0", reg_write, reg_dst, mem_reg);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic zv[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      do_reset(); opcode = 6'b000100; zero = zv[k];
      @(negedge clk); @(negedge clk); #1;
      tests++;
      if (state !== 4'd8 || pc_en !== zv[k] || pc_src !== 2'b01 || alu_control !== 3'b110) begin
        fails++; $display("FAIL beq_zero%0b: state=%0d pc_en=%b pc_src=%b alu=%b, want 8 %b 01 110", zv[k], state, pc_en, pc_src, alu_control, zv[k]);
      end
      @(negedge clk); #1;
      tests++;
      if (state !== 4'd0) begin
        fails++; $display("FAIL beq_return: state=%0d want 0", state);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump_addi();
    do_reset(); opcode = 6'b000010;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (state !== 4'd11 || pc_en !== 1'b1 || pc_src !== 2'b10) begin
      fails++; $display("FAIL jump: state=%0d pc_en=%b pc_src=%b, want 11 1 10", state, pc_en, pc_src);
    end
    do_reset(); opcode = 6'b001000;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (state !== 4'd9 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_control !== 3'b010) begin
      fails++; $display("FAIL addiex: state=%0d src_a=%b src_b=%b alu=%b, want 9 1 10 010", state, alu_src_a, alu_src_b, alu_control);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_reg !== 1'b0) begin
      fails++; $display("FAIL addiwb: state=%0d reg_write=%b reg_dst=%b mem_reg=%b, want 10 1 0 0", state, reg_write, reg_dst, mem_reg);
    end
  endtask

  task automatic test_sw_timeout();
    do_reset(); opcode = 6'b101011; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (state !== 4'd5 || mem_write !== 1'b1 || mem_req !== 1'b1 || iord !== 1'b1 || bus_err !== 1'b0) begin
        fails++; $display("FAIL sw_wait%0d: state=%0d mem_write=%b mem_req=%b iord=%b bus_err=%b, want 5 1 1 1 0", k, state, mem_write, mem_req, iord, bus_err);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (state !== 4'd5 || bus_err !== 1'b1 || mem_write !== 1'b0) begin
      fails++; $display("FAIL sw_timeout: state=%0d bus_err=%b mem_write=%b, want 5 1 0", state, bus_err, mem_write);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0 || bus_err !== 1'b0 || ir_write !== 1'b0) begin
      fails++; $display("FAIL sw_after: state=%0d bus_err=%b ir_write=%b, want 0 0 0", state, bus_err, ir_write);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_ready_on_limit();
    do_reset(); opcode = 6'b100011; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b1; #1;
    tests++;
    if (state !== 4'd3 || bus_err !== 1'b0) begin
      fails++; $display("FAIL ready_on_limit: state=%0d bus_err=%b, want 3 0", state, bus_err);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd4) begin
      fails++; $display("FAIL ready_on_limit_next: state=%0d want 4", state);
    end
    // FETCH timeout: three idle waits, then bus_err with no IR/PC load
    do_reset(); mem_ready = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    tests++;
    if (state !== 4'd0 || bus_err !== 1'b1 || ir_write !== 1'b0 || pc_en !== 1'b0) begin
      fails++; $display("FAIL fetch_timeout: state=%0d bus_err=%b ir_write=%b pc_en=%b, want 0 1 0 0", state, bus_err, ir_write, pc_en);
    end
    @(negedge clk); #1;
    tests++;
    if (bus_err !== 1'b0) begin
      fails++; $display("FAIL fetch_timeout_pulse: bus_err=%b want 0", bus_err);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    do_reset(); opcode = 6'b111111;
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd1 || illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_op: state=%0d illegal=%b, want 1 1", state, illegal);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      fails++; $display("FAIL illegal_op_after: state=%0d illegal=%b, want 0 0", state, illegal);
    end
    do_reset(); opcode = 6'b000101; zero = 1'b0;
    @(negedge clk); #1;
`ifdef CTRL_BNE_EN
    tests++;
    if (illegal !== 1'b0) begin
      fails++; $display("FAIL bne_decode: illegal=%b want 0", illegal);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd8 || pc_en !== 1'b1) begin
      fails++; $display("FAIL bne_branch: state=%0d pc_en=%b, want 8 1", state, pc_en);
    end
`else
    tests++;
    if (illegal !== 1'b1) begin
      fails++; $display("FAIL bne_illegal: illegal=%b want 1", illegal);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0) begin
      fails++; $display("FAIL bne_illegal_after: state=%0d want 0", state);
    end
`endif
    do_reset(); opcode = 6'b000000; funct = 6'b111111;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if (state !== 4'd6 || illegal !== 1'b1) begin
      fails++; $display("FAIL illegal_funct: state=%0d illegal=%b, want 6 1", state, illegal);
    end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0 || reg_write !== 1'b0) begin
      fails++; $display("FAIL illegal_funct_skip: state=%0d reg_write=%b, want 0 0", state, reg_write);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump_addi();
    test_sw_timeout();
    test_ready_on_limit();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
